// File: rtl/dft_pkg.sv
// dft_pkg: shared types and constants for the DFT sample framer.
package dft_pkg;
    localparam int SAMPLE_W = 16;
    localparam int LANES    = 8;
    localparam int GROUPS   = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t group_t [0:LANES-1];
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, HOLD, WAIT_DONE} state_t;
endpackage

// File: rtl/pingpong_bank.sv
// pingpong_bank: two 8-lane sample banks with write pointer, full flags and bank-select read.
module pingpong_bank
    import dft_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  sample_t wr_data,
    input  logic    rd_bank,
    input  logic    clr,
    output logic    ready,
    output logic    rd_full,
    output group_t  rd_data
);
    sample_t mem [0:1][0:LANES-1];
    logic [1:0] full;
    logic wr_bank;
    logic [2:0] wr_lane;
    logic acc;

    assign ready   = !full[wr_bank];
    assign rd_full = full[rd_bank];
    assign acc     = wr_en && ready;

    for (genvar i = 0; i < LANES; i++) begin : g_rd
        assign rd_data[i] = mem[rd_bank][i];
    end

    always_ff @(posedge clk)
        if (acc) mem[wr_bank][wr_lane] <= wr_data;

    // Writer only touches a non-full bank, reader only clears a full one, so they never collide.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_lane <= '0;
        end else begin
            if (clr) full[rd_bank] <= 1'b0;
            if (acc) begin
                wr_lane <= wr_lane + 3'd1;
                if (wr_lane == 3'(LANES-1)) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
        end
endmodule

// File: rtl/dft_sample_framer.sv
// dft_sample_framer: packs a serial sample stream into 8-lane groups and frames them for the DFT stage.
module dft_sample_framer
    import dft_pkg::*;
#(
    parameter int GROUP_GAP = 4
) (
    input  logic       clk,
    input  logic       sreset,
    input  logic       in_valid,
    output logic       in_ready,
    input  sample_t    in_sample,
    input  logic       dft_done,
    output group_t     samples,
    output logic       rel,
    output logic       calculate,
    output logic [2:0] group_idx,
    output logic       busy
);
    state_t state;
    logic rd_bank;
    logic rd_full;
    logic [2:0] grp;
    logic [7:0] gap_cnt;
    group_t rd_data;

    pingpong_bank u_bank (
        .clk     (clk),
        .rst     (sreset),
        .wr_en   (in_valid),
        .wr_data (in_sample),
        .rd_bank (rd_bank),
        .clr     (state == ISSUE),
        .ready   (in_ready),
        .rd_full (rd_full),
        .rd_data (rd_data)
    );

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge sreset)
        if (sreset) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            grp       <= '0;
            gap_cnt   <= '0;
            rel       <= 1'b0;
            calculate <= 1'b0;
            group_idx <= '0;
            samples   <= '{default: '0};
        end else begin
            rel <= 1'b0;
            case (state)
                IDLE, HOLD: if (rd_full) state <= ISSUE;
                ISSUE: begin
                    samples   <= rd_data;
                    rel       <= 1'b1;
                    rd_bank   <= !rd_bank;
                    group_idx <= grp;
                    grp       <= grp + 3'd1;
                    gap_cnt   <= 8'(GROUP_GAP - 1);
                    if (grp == 3'd0) calculate <= 1'b1;
                    state <= (grp == 3'(GROUPS-1)) ? WAIT_DONE : GAP;
                end
                GAP: if (gap_cnt == 8'd0) state <= HOLD; else gap_cnt <= gap_cnt - 8'd1;
                WAIT_DONE: if (dft_done) begin
                    calculate <= 1'b0;
                    grp       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dft_sample_framer.sv
// tb_dft_sample_framer: scoreboard bench for the framer (GROUP_GAP 4) plus a GROUP_GAP 12 instance for throttling.
module tb_dft_sample_framer;
    import dft_pkg::*;

    typedef struct {logic [127:0] d; logic [2:0] idx;} exp_t;

    logic clk = 1'b0, sreset = 1'b1, in_valid = 1'b0, in_valid2 = 1'b0, dft_done = 1'b0;
    sample_t in_sample = '0;
    logic in_ready, in_ready2, rel, rel2, calculate, calculate2, busy, busy2;
    logic [2:0] group_idx, group_idx2;
    group_t samples, samples2, cur;
    exp_t q[$];
    int rel_t[$], rel2_t[$];
    int ncmp = 0, nbad = 0, cyc = 0, rel_n = 0, rel2n = 0, acc2 = 0, part = 0, kgrp = 0, next_val = 0;
    logic saw_full2 = 1'b0;

    always #5 clk = ~clk;

    dft_sample_framer #(.GROUP_GAP(4)) dut (
        .clk(clk), .sreset(sreset), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .dft_done(dft_done), .samples(samples), .rel(rel), .calculate(calculate),
        .group_idx(group_idx), .busy(busy)
    );

    dft_sample_framer #(.GROUP_GAP(12)) dut2 (
        .clk(clk), .sreset(sreset), .in_valid(in_valid2), .in_ready(in_ready2), .in_sample(in_sample),
        .dft_done(1'b0), .samples(samples2), .rel(rel2), .calculate(calculate2),
        .group_idx(group_idx2), .busy(busy2)
    );

    function automatic logic [127:0] pk(input group_t g);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[127-16*i -: 16] = g[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: groups become pending at acceptance of lane 7 and are retired by rel.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sreset) begin
            q.delete(); rel_t.delete(); rel2_t.delete();
            rel_n = 0; rel2n = 0; acc2 = 0; part = 0; kgrp = 0; saw_full2 = 1'b0;
        end else begin
            if (rel) begin
                rel_n++;
                rel_t.push_back(cyc);
                chk("calc_at_rel", 128'(calculate), 128'(1'b1));
                chk("rel_pending", 128'(q.size() > 0), 128'(1'b1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("group_data", pk(samples), e.d);
                    chk("group_idx", 128'(group_idx), 128'(e.idx));
                end
            end
            chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
            if (in_valid && in_ready) begin
                cur[part] = in_sample;
                part++;
                if (part == 8) begin
                    e.d = pk(cur);
                    e.idx = 3'(kgrp);
                    q.push_back(e);
                    kgrp++;
                    part = 0;
                end
            end
            if (rel2) begin
                rel2n++;
                rel2_t.push_back(cyc);
            end
            chk("in_ready2", 128'(in_ready2), 128'((acc2 / 8 - rel2n) < 2));
            if (!in_ready2) saw_full2 = 1'b1;
            if (in_valid2 && in_ready2) acc2++;
        end
    end

    task automatic feed(input int n, input int pct, input int budget, output int sent);
        int c = 0;
        logic acc;
        sent = 0;
        while (sent < n && c < budget) begin
            in_valid = int'($urandom_range(99)) < pct;
            in_sample = sample_t'(next_val);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            c++;
            if (acc) begin
                sent++;
                next_val++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rel(input int target, input int budget);
        int c = 0;
        while (rel_n < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("rel_timeout", 128'(rel_n >= target), 128'(1'b1));
    endtask

    task automatic pulse_done();
        chk("calc_before_done", 128'(calculate), 128'(1'b1));
        dft_done = 1'b1;
        @(posedge clk);
        #1;
        dft_done = 1'b0;
        chk("calc_after_done", 128'(calculate), 128'(1'b0));
        chk("idle_after_done", 128'(busy), 128'(1'b0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 sreset = 1'b1;
        #1;
        chk("rst_samples", pk(samples), 128'(0));
        chk("rst_rel", 128'(rel), 128'(1'b0));
        chk("rst_calc", 128'(calculate), 128'(1'b0));
        chk("rst_gidx", 128'(group_idx), 128'(0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        @(posedge clk);
        #1 sreset = 1'b0;
        chk("rst_ready", 128'(in_ready), 128'(1'b1));
    endtask

    initial begin
        int s;
        int c;
        repeat (2) @(posedge clk);
        #1 sreset = 1'b0;

        do_reset();
        next_val = 1000;
        feed(20, 100, 100, s);
        chk("t1_fed", 128'(s), 128'(20));
        do_reset();
        next_val = 500;
        feed(8, 100, 50, s);
        wait_rel(1, 20);

        do_reset();
        next_val = 0;
        feed(64, 100, 200, s);
        wait_rel(8, 50);
        for (int i = 1; i < 8; i++) chk("t2_spacing", 128'(rel_t[i] - rel_t[i-1]), 128'(8));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        pulse_done();

        do_reset();
        in_valid2 = 1'b1;
        c = 0;
        while (rel2n < 8 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        in_valid2 = 1'b0;
        chk("t3_rels", 128'(rel2n >= 8), 128'(1'b1));
        for (int i = 1; i < 8; i++) chk("t3_spacing", 128'(rel2_t[i] - rel2_t[i-1]), 128'(14));
        chk("t3_backpressure", 128'(saw_full2), 128'(1'b1));

        do_reset();
        next_val = 0;
        feed(100, 100, 400, s);
        chk("t4_accepted", 128'(s), 128'(80));
        chk("t4_ready", 128'(in_ready), 128'(1'b0));
        chk("t4_calc", 128'(calculate), 128'(1'b1));
        chk("t4_rels", 128'(rel_n), 128'(8));
        pulse_done();
        wait_rel(9, 50);
        chk("t4_f2_gidx", 128'(group_idx), 128'(0));

        do_reset();
        next_val = 0;
        feed(64, 30, 2000, s);
        chk("t5_fed", 128'(s), 128'(64));
        wait_rel(8, 50);
        pulse_done();

        do_reset();
        next_val = 0;
        fork
            feed(64, 100, 200, s);
            begin
                wait_rel(4, 200);
                dft_done = 1'b1;
                @(posedge clk);
                #1 dft_done = 1'b0;
                chk("t6_calc_kept", 128'(calculate), 128'(1'b1));
                chk("t6_busy_kept", 128'(busy), 128'(1'b1));
            end
        join
        wait_rel(8, 50);
        chk("t6_rels", 128'(rel_n), 128'(8));
        pulse_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
